// File: rtl/bop_pkg.sv
// -----------------------------------------------------------------------------
// bop_pkg
// Definitions shared by the best-offset prefetcher and the prefetch issue
// scheduler: default address width, cache-line offset width, and the request
// record held in the scheduler's output stage.
//
// Ports: none (package).
// -----------------------------------------------------------------------------
package bop_pkg;

  // Default address width. Modules may narrow WIDTH, but not widen it beyond
  // this value, because req_t carries the address at this width.
  localparam int DEF_WIDTH   = 64;

  // Number of line-offset bits. These bits are ignored when two addresses are
  // compared for the same cache line.
  localparam int DEF_LOGLINE = 6;

  // One request to the lower-level cache.
  typedef struct packed {
    logic [DEF_WIDTH-1:0] address;
    logic                 is_prefetch;
  } req_t;

endpackage : bop_pkg

// File: rtl/prefetch_issue_scheduler_if.sv
// -----------------------------------------------------------------------------
// prefetch_issue_scheduler_if
// Bundles the demand-miss input, the prefetch input, the lower-level request
// output and the drop/count status of the prefetch issue scheduler.
//
// modport slave  : scheduler side (receives dm_*/pf_*/lo_ready_i, drives the rest)
// modport master : requester / cache side (the mirror image)
//
//   dm_valid_i, dm_address_i, dm_ready_o      demand miss handshake
//   pf_valid_i, pf_address_i                  prefetch request (never stalled)
//   lo_valid_o, lo_ready_i, lo_address_o,
//   lo_is_prefetch_o                          request to the lower-level cache
//   pf_drop_o                                 one-cycle pulse, a prefetch was discarded
//   pf_count_o                                live queued prefetches
// -----------------------------------------------------------------------------
interface prefetch_issue_scheduler_if #(
  parameter int WIDTH  = bop_pkg::DEF_WIDTH,
  parameter int QDEPTH = 4
);

  localparam int CW = $clog2(QDEPTH) + 1;

  logic             dm_valid_i;
  logic [WIDTH-1:0] dm_address_i;
  logic             dm_ready_o;
  logic             pf_valid_i;
  logic [WIDTH-1:0] pf_address_i;
  logic             lo_ready_i;
  logic             lo_valid_o;
  logic [WIDTH-1:0] lo_address_o;
  logic             lo_is_prefetch_o;
  logic             pf_drop_o;
  logic [CW-1:0]    pf_count_o;

  modport slave (
    input  dm_valid_i, dm_address_i, pf_valid_i, pf_address_i, lo_ready_i,
    output dm_ready_o, lo_valid_o, lo_address_o, lo_is_prefetch_o,
           pf_drop_o, pf_count_o
  );

  modport master (
    output dm_valid_i, dm_address_i, pf_valid_i, pf_address_i, lo_ready_i,
    input  dm_ready_o, lo_valid_o, lo_address_o, lo_is_prefetch_o,
           pf_drop_o, pf_count_o
  );

endinterface : prefetch_issue_scheduler_if

// File: rtl/pf_issue_queue.sv
// -----------------------------------------------------------------------------
// pf_issue_queue
// Circular FIFO of prefetch line numbers. Each slot has a live bit, so that
// squashed entries can stay in place and be skipped later. The FIFO also
// provides the line-match logic that the scheduler needs.
//
//   clk, rst         clock, asynchronous active-low reset
//   push, push_line  enqueue a line (already filtered for duplicates)
//   issue            the scheduler takes the live head this cycle
//   squash,
//   squash_line      clear every live entry on this line (accepted demand)
//   probe_line,
//   probe_hit        does a live entry hold this line (incoming prefetch)
//   head_live,
//   head_line        head entry, and whether it is live
//   any_live         at least one live entry
//   overflow         a push onto a full queue discarded the oldest entry
//   squash_hit       the squash cleared at least one entry
//   count            live entries after this cycle's updates (registered)
// -----------------------------------------------------------------------------
module pf_issue_queue
  import bop_pkg::*;
#(
  parameter  int WIDTH   = DEF_WIDTH,
  parameter  int QDEPTH  = 4,
  parameter  int LOGLINE = DEF_LOGLINE,
  localparam int LW      = WIDTH - LOGLINE,
  localparam int CW      = $clog2(QDEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [LW-1:0] push_line,
  input  logic          issue,
  input  logic          squash,
  input  logic [LW-1:0] squash_line,
  input  logic [LW-1:0] probe_line,
  output logic          probe_hit,
  output logic          head_live,
  output logic [LW-1:0] head_line,
  output logic          any_live,
  output logic          overflow,
  output logic          squash_hit,
  output logic [CW-1:0] count
);

  localparam int PW = $clog2(QDEPTH);

  logic [LW-1:0]     line_q [QDEPTH];
  logic [QDEPTH-1:0] live_q, live_d;
  logic [QDEPTH-1:0] probe_vec, squash_vec;
  logic [PW-1:0]     head_q, tail_q;
  logic [CW-1:0]     occ_q, occ_d;
  logic              full, pop;

  assign full      = (occ_q == CW'(QDEPTH));
  assign head_live = live_q[head_q];
  assign head_line = line_q[head_q];
  assign any_live  = |live_q;

  // A dead head is retired on its own, and does not use an output slot.
  assign pop        = ((occ_q != '0) & ~live_q[head_q]) | issue;
  assign overflow   = push & full & ~pop;
  assign probe_hit  = |probe_vec;
  assign squash_hit = squash & (|squash_vec);

  // NOTE: every variable assigned in an always_comb gets a default value first.
  // Without it, a path that does not write the variable infers a latch.
  always_comb begin
    probe_vec  = '0;
    squash_vec = '0;
    for (int i = 0; i < QDEPTH; i++) begin
      probe_vec[i]  = live_q[i] & (line_q[i] == probe_line);
      squash_vec[i] = live_q[i] & (line_q[i] == squash_line);
    end
  end

  // The writes are ordered: squash, then retire the head, then push.
  // On overflow head == tail, so the overwritten slot becomes live again.
  always_comb begin
    live_d = live_q;
    if (squash) live_d = live_d & ~squash_vec;
    if (pop || overflow) live_d[head_q] = 1'b0;
    if (push) live_d[tail_q] = 1'b1;
  end

  always_comb begin
    occ_d = occ_q;
    if (push && !overflow) occ_d = occ_d + CW'(1);
    if (pop) occ_d = occ_d - CW'(1);
  end

  // NOTE: sequential state uses non-blocking assignments only. Every flop then
  // samples values from before the clock edge, whatever order the code is in.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
      live_q <= '0;
      count  <= '0;
    end else begin
      if (pop || overflow) head_q <= head_q + PW'(1);
      if (push) tail_q <= tail_q + PW'(1);
      occ_q  <= occ_d;
      live_q <= live_d;
      count  <= CW'($countones(live_d));
    end
  end

  // NOTE: the line storage has no reset. The live bits qualify every read, so
  // resetting the array would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (push) line_q[tail_q] <= push_line;
  end

endmodule : pf_issue_queue

// File: rtl/prefetch_issue_scheduler.sv
// -----------------------------------------------------------------------------
// prefetch_issue_scheduler
// Merges demand misses and queued prefetches into one request stream to the
// lower-level cache. Demands win arbitration unless prefetches have starved
// for STARVE_MAX consecutive demand wins. Duplicate prefetches are dropped.
// Prefetches on the line of an accepted demand are squashed. Requests are
// issued line-aligned, from a single output register.
//
//   clk  clock
//   rst  asynchronous active-low reset
//   bus  prefetch_issue_scheduler_if.slave (demand, prefetch, lower level, status)
// -----------------------------------------------------------------------------
module prefetch_issue_scheduler
  import bop_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int QDEPTH     = 4,
  parameter int STARVE_MAX = 8,
  parameter int LOGLINE    = DEF_LOGLINE
) (
  input  logic clk,
  input  logic rst,
  prefetch_issue_scheduler_if.slave bus
);

  localparam int LW = WIDTH - LOGLINE;
  localparam int CW = $clog2(QDEPTH) + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);

  req_t          out_q, out_d;
  logic          out_valid_q, out_valid_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          drop_q, drop_d;

  logic [LW-1:0] dm_line, pf_line, out_line, head_line;
  logic          slot_free, force_pf, load_pf, load_dm;
  logic          dup, push;
  logic          probe_hit, head_live, any_live, overflow, squash_hit;
  logic [CW-1:0] pf_count;

  // Line offsets never take part in matching and are never forwarded.
  logic          unused_offset_bits;
  assign unused_offset_bits = ^{bus.dm_address_i[LOGLINE-1:0],
                                bus.pf_address_i[LOGLINE-1:0]};

  assign dm_line  = bus.dm_address_i[WIDTH-1:LOGLINE];
  assign pf_line  = bus.pf_address_i[WIDTH-1:LOGLINE];
  assign out_line = out_q.address[WIDTH-1:LOGLINE];

  // The output register can be loaded when it is empty, or when its contents
  // leave this cycle.
  assign slot_free = ~out_valid_q | bus.lo_ready_i;
  assign force_pf  = (starve_q == STARVE_TOP) & head_live;
  assign load_pf   = slot_free & head_live & (force_pf | ~bus.dm_valid_i);
  assign load_dm   = slot_free & ~force_pf & bus.dm_valid_i;

  // An incoming prefetch is redundant if its line is already queued, already
  // in the output register, or presented as a demand in this same cycle.
  assign dup  = probe_hit
              | (out_valid_q & (out_line == pf_line))
              | (bus.dm_valid_i & (dm_line == pf_line));
  assign push = bus.pf_valid_i & ~dup;

  pf_issue_queue #(
    .WIDTH   (WIDTH),
    .QDEPTH  (QDEPTH),
    .LOGLINE (LOGLINE)
  ) u_queue (
    .clk         (clk),
    .rst         (rst),
    .push        (push),
    .push_line   (pf_line),
    .issue       (load_pf),
    .squash      (load_dm),
    .squash_line (dm_line),
    .probe_line  (pf_line),
    .probe_hit   (probe_hit),
    .head_live   (head_live),
    .head_line   (head_line),
    .any_live    (any_live),
    .overflow    (overflow),
    .squash_hit  (squash_hit),
    .count       (pf_count)
  );

  always_comb begin
    out_valid_d = out_valid_q;
    out_d       = out_q;
    if (slot_free) begin
      if (load_pf) begin
        out_valid_d       = 1'b1;
        out_d.address     = DEF_WIDTH'({head_line, {LOGLINE{1'b0}}});
        out_d.is_prefetch = 1'b1;
      end else if (load_dm) begin
        out_valid_d       = 1'b1;
        out_d.address     = DEF_WIDTH'({dm_line, {LOGLINE{1'b0}}});
        out_d.is_prefetch = 1'b0;
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  // The starvation count runs only while a prefetch is waiting. It saturates,
  // so force_pf stays raised until a prefetch is actually loaded.
  always_comb begin
    starve_d = starve_q;
    if (!any_live || load_pf) begin
      starve_d = '0;
    end else if (load_dm && starve_q != STARVE_TOP) begin
      starve_d = starve_q + SW'(1);
    end
  end

  // All drop causes merge into one pulse.
  assign drop_d = (bus.pf_valid_i & dup) | overflow | squash_hit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
      starve_q    <= '0;
      drop_q      <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      starve_q    <= starve_d;
      drop_q      <= drop_d;
    end
  end

  assign bus.dm_ready_o       = slot_free & ~force_pf;
  assign bus.lo_valid_o       = out_valid_q;
  assign bus.lo_address_o     = out_q.address[WIDTH-1:0];
  assign bus.lo_is_prefetch_o = out_q.is_prefetch;
  assign bus.pf_drop_o        = drop_q;
  assign bus.pf_count_o       = pf_count;

endmodule : prefetch_issue_scheduler

// File: tb/tb_prefetch_issue_scheduler.sv
// -----------------------------------------------------------------------------
// tb_prefetch_issue_scheduler
// Directed bench for prefetch_issue_scheduler. Each scenario task drives its
// stimulus and compares the outputs against hand-computed values. A monitor
// logs every lower-level transfer and counts drop pulses.
// -----------------------------------------------------------------------------
module tb_prefetch_issue_scheduler;

  localparam int WIDTH      = 64;
  localparam int QDEPTH     = 4;
  localparam int STARVE_MAX = 8;
  localparam int LOGLINE    = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int checks   = 0;
  int failures = 0;
  int drop_cnt = 0;

  logic [WIDTH-1:0] log_addr [$];
  logic             log_pf   [$];

  prefetch_issue_scheduler_if #(.WIDTH(WIDTH), .QDEPTH(QDEPTH)) bus ();

  prefetch_issue_scheduler #(
    .WIDTH      (WIDTH),
    .QDEPTH     (QDEPTH),
    .STARVE_MAX (STARVE_MAX),
    .LOGLINE    (LOGLINE)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Inputs change just after posedge, so the negedge sees the values that
  // the next posedge will act on.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (bus.lo_valid_o === 1'b1 && bus.lo_ready_i === 1'b1) begin
        log_addr.push_back(bus.lo_address_o);
        log_pf.push_back(bus.lo_is_prefetch_o);
      end
      if (bus.pf_drop_o === 1'b1) drop_cnt++;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.dm_valid_i   = 1'b0;
    bus.dm_address_i = '0;
    bus.pf_valid_i   = 1'b0;
    bus.pf_address_i = '0;
  endtask

  task automatic clear_log();
    log_addr.delete();
    log_pf.delete();
  endtask

  // Compares the transfer log with an expected sequence of n entries.
  task automatic check_log(input string name, input int n,
                           input logic [WIDTH-1:0] ea [16], input logic ep [16]);
    checks++;
    if (log_addr.size() != n) begin
      failures++;
      $display("FAIL %s_count: got %0d transfers, expected %0d", name, log_addr.size(), n);
    end
    for (int i = 0; i < n; i++) begin
      logic [WIDTH-1:0] a;
      logic             p;
      a = (i < log_addr.size()) ? log_addr[i] : '1;
      p = (i < log_pf.size()) ? log_pf[i] : 1'bx;
      checks++;
      if (a !== ea[i] || p !== ep[i]) begin
        failures++;
        $display("FAIL %s[%0d]: got addr=%h pf=%b, expected addr=%h pf=%b",
                 name, i, a, p, ea[i], ep[i]);
      end
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    bus.lo_ready_i = 1'b0;
    #1 rst = 1'b0;
    #2;
    checks++;
    if (bus.lo_valid_o !== 1'b0 || bus.lo_address_o !== '0 || bus.lo_is_prefetch_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_out: got v=%b a=%h p=%b, expected 0/0/0",
               bus.lo_valid_o, bus.lo_address_o, bus.lo_is_prefetch_o);
    end
    checks++;
    if (bus.pf_drop_o !== 1'b0 || bus.pf_count_o !== '0) begin
      failures++;
      $display("FAIL reset_status: got drop=%b count=%0d, expected 0/0", bus.pf_drop_o, bus.pf_count_o);
    end
    checks++;
    if (bus.dm_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL reset_dm_ready: got %b expected 1", bus.dm_ready_o);
    end
    tick();
    tick();
    rst = 1'b1;
    tick();
    checks++;
    if (bus.lo_valid_o !== 1'b0 || bus.pf_count_o !== '0) begin
      failures++;
      $display("FAIL reset_release: got v=%b count=%0d, expected 0/0", bus.lo_valid_o, bus.pf_count_o);
    end
  endtask

  task automatic test_demand();
    logic [WIDTH-1:0] ea [16];
    logic             ep [16];
    clear_log();
    bus.lo_ready_i   = 1'b1;
    bus.dm_valid_i   = 1'b1;
    bus.dm_address_i = 64'h1040;
    #1;
    checks++;
    if (bus.dm_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL demand_ready: got %b expected 1", bus.dm_ready_o);
    end
    tick();
    idle_inputs();
    checks++;
    if (bus.lo_valid_o !== 1'b1 || bus.lo_address_o !== 64'h1040 || bus.lo_is_prefetch_o !== 1'b0) begin
      failures++;
      $display("FAIL demand_issue: got v=%b a=%h p=%b, expected 1/1040/0",
               bus.lo_valid_o, bus.lo_address_o, bus.lo_is_prefetch_o);
    end
    tick();
    checks++;
    if (bus.lo_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL demand_empty: got v=%b expected 0", bus.lo_valid_o);
    end
    ea[0] = 64'h1040; ep[0] = 1'b0;
    check_log("demand_log", 1, ea, ep);
  endtask

  task automatic test_overflow();
    logic [WIDTH-1:0] ea [16];
    logic             ep [16];
    logic [WIDTH-1:0] pf_seq [5];
    pf_seq = '{64'h2000, 64'h2040, 64'h2080, 64'h20C0, 64'h2100};
    // Park a demand in the output stage, so the queue cannot drain.
    bus.lo_ready_i   = 1'b0;
    bus.dm_valid_i   = 1'b1;
    bus.dm_address_i = 64'h1080;
    tick();
    idle_inputs();
    for (int i = 0; i < 5; i++) begin
      bus.pf_valid_i   = 1'b1;
      bus.pf_address_i = pf_seq[i];
      tick();
      if (i == 3) begin
        checks++;
        if (bus.pf_count_o !== 3'd4 || bus.pf_drop_o !== 1'b0) begin
          failures++;
          $display("FAIL overflow_fill: got count=%0d drop=%b, expected 4/0", bus.pf_count_o, bus.pf_drop_o);
        end
      end
    end
    idle_inputs();
    checks++;
    if (bus.pf_drop_o !== 1'b1 || bus.pf_count_o !== 3'd4) begin
      failures++;
      $display("FAIL overflow_drop: got drop=%b count=%0d, expected 1/4", bus.pf_drop_o, bus.pf_count_o);
    end
    tick();
    checks++;
    if (bus.pf_drop_o !== 1'b0) begin
      failures++;
      $display("FAIL overflow_pulse: got drop=%b expected 0", bus.pf_drop_o);
    end
    clear_log();
    bus.lo_ready_i = 1'b1;
    repeat (6) tick();
    ea[0] = 64'h1080; ep[0] = 1'b0;
    ea[1] = 64'h2040; ep[1] = 1'b1;
    ea[2] = 64'h2080; ep[2] = 1'b1;
    ea[3] = 64'h20C0; ep[3] = 1'b1;
    ea[4] = 64'h2100; ep[4] = 1'b1;
    check_log("overflow_log", 5, ea, ep);
    checks++;
    if (bus.pf_count_o !== '0) begin
      failures++;
      $display("FAIL overflow_drained: got count=%0d expected 0", bus.pf_count_o);
    end
  endtask

  task automatic test_squash();
    logic [WIDTH-1:0] ea [16];
    logic             ep [16];
    clear_log();
    bus.lo_ready_i   = 1'b0;
    bus.dm_valid_i   = 1'b1;
    bus.dm_address_i = 64'h5000;
    tick();
    idle_inputs();
    bus.pf_valid_i   = 1'b1;
    bus.pf_address_i = 64'h3000;
    tick();
    idle_inputs();
    checks++;
    if (bus.pf_count_o !== 3'd1) begin
      failures++;
      $display("FAIL squash_queued: got count=%0d expected 1", bus.pf_count_o);
    end
    bus.lo_ready_i   = 1'b1;
    bus.dm_valid_i   = 1'b1;
    bus.dm_address_i = 64'h3010;
    tick();
    idle_inputs();
    checks++;
    if (bus.pf_drop_o !== 1'b1 || bus.pf_count_o !== '0) begin
      failures++;
      $display("FAIL squash_drop: got drop=%b count=%0d, expected 1/0", bus.pf_drop_o, bus.pf_count_o);
    end
    checks++;
    if (bus.lo_valid_o !== 1'b1 || bus.lo_address_o !== 64'h3000 || bus.lo_is_prefetch_o !== 1'b0) begin
      failures++;
      $display("FAIL squash_issue: got v=%b a=%h p=%b, expected 1/3000/0",
               bus.lo_valid_o, bus.lo_address_o, bus.lo_is_prefetch_o);
    end
    repeat (3) tick();
    ea[0] = 64'h5000; ep[0] = 1'b0;
    ea[1] = 64'h3000; ep[1] = 1'b0;
    check_log("squash_log", 2, ea, ep);
  endtask

  task automatic test_starve();
    logic [WIDTH-1:0] ea [16];
    logic             ep [16];
    int               k;
    bus.lo_ready_i   = 1'b0;
    bus.dm_valid_i   = 1'b1;
    bus.dm_address_i = 64'h6000;
    tick();
    idle_inputs();
    bus.pf_valid_i   = 1'b1;
    bus.pf_address_i = 64'h7000;
    tick();
    idle_inputs();
    clear_log();
    bus.lo_ready_i = 1'b1;
    bus.dm_valid_i = 1'b1;
    k = 1;
    for (int c = 1; c <= 10; c++) begin
      logic exp_ready;
      bus.dm_address_i = 64'h8000 + 64'(k) * 64'h40;
      #1;
      exp_ready = (c == 9) ? 1'b0 : 1'b1;
      checks++;
      if (bus.dm_ready_o !== exp_ready) begin
        failures++;
        $display("FAIL starve_ready_c%0d: got %b expected %b", c, bus.dm_ready_o, exp_ready);
      end
      if (bus.dm_ready_o === 1'b1) k++;
      tick();
    end
    idle_inputs();
    repeat (2) tick();
    ea[0] = 64'h6000; ep[0] = 1'b0;
    for (int j = 1; j <= 8; j++) begin
      ea[j] = 64'h8000 + 64'(j) * 64'h40;
      ep[j] = 1'b0;
    end
    ea[9]  = 64'h7000; ep[9]  = 1'b1;
    ea[10] = 64'h8240; ep[10] = 1'b0;
    check_log("starve_log", 11, ea, ep);
  endtask

  task automatic test_duplicate();
    logic [WIDTH-1:0] ea [16];
    logic             ep [16];
    int               d0;
    clear_log();
    d0 = drop_cnt;
    bus.lo_ready_i   = 1'b1;
    bus.pf_valid_i   = 1'b1;
    bus.pf_address_i = 64'h4000;
    tick();
    tick();
    idle_inputs();
    checks++;
    if (bus.pf_drop_o !== 1'b1) begin
      failures++;
      $display("FAIL dup_drop: got %b expected 1", bus.pf_drop_o);
    end
    repeat (3) tick();
    ea[0] = 64'h4000; ep[0] = 1'b1;
    check_log("dup_log", 1, ea, ep);
    checks++;
    if (drop_cnt - d0 != 1) begin
      failures++;
      $display("FAIL dup_pulses: got %0d expected 1", drop_cnt - d0);
    end
  endtask

  task automatic test_pf_vs_demand();
    logic [WIDTH-1:0] ea [16];
    logic             ep [16];
    clear_log();
    bus.lo_ready_i   = 1'b1;
    bus.dm_valid_i   = 1'b1;
    bus.dm_address_i = 64'h9000;
    bus.pf_valid_i   = 1'b1;
    bus.pf_address_i = 64'h9020;
    tick();
    idle_inputs();
    checks++;
    if (bus.pf_drop_o !== 1'b1 || bus.pf_count_o !== '0) begin
      failures++;
      $display("FAIL same_cycle_drop: got drop=%b count=%0d, expected 1/0", bus.pf_drop_o, bus.pf_count_o);
    end
    repeat (3) tick();
    ea[0] = 64'h9000; ep[0] = 1'b0;
    check_log("same_cycle_log", 1, ea, ep);
  endtask

  task automatic test_reset_midflight();
    bus.lo_ready_i   = 1'b0;
    bus.dm_valid_i   = 1'b1;
    bus.dm_address_i = 64'hA000;
    tick();
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      bus.pf_valid_i   = 1'b1;
      bus.pf_address_i = 64'hB000 + 64'(i) * 64'h40;
      tick();
    end
    idle_inputs();
    checks++;
    if (bus.lo_valid_o !== 1'b1 || bus.pf_count_o !== 3'd3) begin
      failures++;
      $display("FAIL midflight_setup: got v=%b count=%0d, expected 1/3", bus.lo_valid_o, bus.pf_count_o);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (bus.lo_valid_o !== 1'b0 || bus.pf_count_o !== '0 || bus.lo_address_o !== '0) begin
      failures++;
      $display("FAIL midflight_async: got v=%b count=%0d a=%h, expected 0/0/0",
               bus.lo_valid_o, bus.pf_count_o, bus.lo_address_o);
    end
    #2 rst = 1'b1;
    bus.lo_ready_i = 1'b1;
    tick();
    checks++;
    if (bus.lo_valid_o !== 1'b0 || bus.pf_count_o !== '0) begin
      failures++;
      $display("FAIL midflight_after: got v=%b count=%0d, expected 0/0", bus.lo_valid_o, bus.pf_count_o);
    end
  endtask

  initial begin
    idle_inputs();
    bus.lo_ready_i = 1'b0;
    test_reset();
    test_demand();
    test_overflow();
    test_squash();
    test_starve();
    test_duplicate();
    test_pf_vs_demand();
    test_reset_midflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_prefetch_issue_scheduler

// File: doc/prefetch_issue_scheduler.md
PREFETCH_ISSUE_SCHEDULER -- requirements
Module: prefetch_issue_scheduler

Interface
REQ-001 SHALL have parameter WIDTH, default 64, address width.
REQ-002 SHALL have parameter QDEPTH, default 4, prefetch queue entries (power of two).
REQ-003 SHALL have parameter STARVE_MAX, default 8, consecutive demand wins before a prefetch is forced.
REQ-004 SHALL have parameter LOGLINE, default 6, line-offset bits ignored for matching.
REQ-005 clk  in  1  single clock; all state on posedge.
REQ-006 rst  in  1  asynchronous, active-low reset.
REQ-007 dm_valid_i  in  1  demand miss request valid.
REQ-008 dm_address_i  in  WIDTH  demand miss address.
REQ-009 dm_ready_o  out  1  demand accepted this cycle.
REQ-010 pf_valid_i  in  1  prefetch request from offset prefetcher.
REQ-011 pf_address_i  in  WIDTH  prefetch address.
REQ-012 lo_ready_i  in  1  lower-level cache accepts a request.
REQ-013 lo_valid_o  out  1  request valid to lower level.
REQ-014 lo_address_o  out  WIDTH  request address, line-aligned (low LOGLINE bits zero).
REQ-015 lo_is_prefetch_o  out  1  1 = issued request is a prefetch.
REQ-016 pf_drop_o  out  1  one-cycle pulse: a prefetch was discarded (overflow, duplicate or demand squash).
REQ-017 pf_count_o  out  $clog2(QDEPTH)+1  count of live queued prefetches.

Function
REQ-018 Output stage SHALL be one register (valid, address, is_prefetch); lo transfer occurs when lo_valid_o & lo_ready_i.
REQ-019 Output register SHALL be loadable when empty or transferring this cycle ("slot free"); demand-to-lo latency is exactly 1 cycle when slot free.
REQ-020 Output register SHALL hold all fields stable while lo_valid_o & ~lo_ready_i.
REQ-021 dm_ready_o SHALL equal slot free & ~force_pf, combinationally.
REQ-022 Prefetches SHALL enter a circular FIFO of QDEPTH entries (head, tail, per-entry live bit); pf input is never back-pressured.
REQ-023 Incoming prefetch whose line matches a live queue entry, the output register, or same-cycle dm_address_i with dm_valid_i SHALL be dropped with pf_drop_o.
REQ-024 Accepted demand whose line matches live queue entries SHALL clear their live bits (squash), pulsing pf_drop_o.
REQ-025 Push to a full queue with no same-cycle pop SHALL overwrite the oldest entry (head advances), pulsing pf_drop_o; simultaneous pop and push when full SHALL drop nothing.
REQ-026 Dead entries at head SHALL be popped without issue, one per cycle, consuming no output slot.
REQ-027 Arbitration when slot free: force_pf = (starve_cnt == STARVE_MAX) & live head; if force_pf, load head prefetch; else demand if dm_valid_i; else live head prefetch; else output becomes invalid.
REQ-028 starve_cnt SHALL increment (saturating at STARVE_MAX) each cycle a demand is loaded while a live entry exists, and clear when a prefetch is loaded or queue has no live entry.
REQ-029 pf_count_o SHALL reflect live entries after the current cycle's updates (registered).
REQ-030 Multiple drop causes in one cycle SHALL produce a single pf_drop_o pulse.

Reset
REQ-031 On rst low, immediately: lo_valid_o=0, lo_address_o=0, lo_is_prefetch_o=0, pf_drop_o=0, pf_count_o=0, head=tail=0, all live bits 0, starve_cnt=0.
REQ-032 Reset mid-transfer SHALL discard the in-flight output and all queued prefetches; no request issues in the first cycle after release unless loaded on that edge.

Structure
REQ-033 WIDTH default, LOGLINE, and a request struct (address, is_prefetch) SHALL live in shared package bop_pkg, also used by best_offset_prefetcher.
REQ-034 The FIFO with live bits and line-match ports SHALL be sub-module pf_issue_queue; arbitration and output register stay in the top.

Verification
REQ-035 Demand 0x1040 with lo_ready_i=1, queue empty -> lo_valid_o next cycle, address 0x1040, lo_is_prefetch_o=0.
REQ-036 Push prefetches 0x2000,0x2040,0x2080,0x20C0,0x2100 with lo_ready_i=0 -> fifth push pf_drop_o=1, queue holds 0x2040..0x2100, pf_count_o=4.
REQ-037 Queue 0x3000, then demand 0x3010 -> 0x3000 squashed, pf_drop_o=1, only demand 0x3000 issued, lo_is_prefetch_o=0.
REQ-038 Continuous demands with one queued prefetch, lo_ready_i=1 -> after 8 demand issues, 9th issue is the prefetch and dm_ready_o=0 that cycle.
REQ-039 Prefetch 0x4000 twice in successive cycles -> second pf_drop_o=1, exactly one lo issue of 0x4000.
REQ-040 Assert rst low while lo_valid_o=1, lo_ready_i=0 and 3 queued -> lo_valid_o=0 and pf_count_o=0 before next clock edge.
